// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment hex writer:
//   state_t     - sequencer states (IDLE, REQ, WRITE, DONE)
//   NUM_DIGITS  - hex digits per displayed value (6)
//   NUM_PLANES  - segment-plane words written per update (5)
//   HEX_TABLE   - nibble -> lit-segment pattern, bit0 = a ... bit6 = g
//   pack_plane  - gathers one segment plane out of the six digit patterns
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int NUM_PLANES = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [NUM_DIGITS-1:0][6:0] seg_vec_t;

   localparam logic [6:0] HEX_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Digit 0 always lands in the most significant used bit (or bit pair) of a
   // plane; digit 5 lands in bit 0 (or bits 1:0). Two-segment planes put the
   // first-named segment in the upper bit of each pair.
   function automatic logic [31:0] pack_plane(input logic [2:0] plane, input seg_vec_t seg);
      logic [31:0] word;
      case (plane)
         3'd0: word = {26'd0, seg[0][0], seg[1][0], seg[2][0], seg[3][0], seg[4][0], seg[5][0]};
         3'd1: word = {20'd0, seg[0][1], seg[0][5], seg[1][1], seg[1][5], seg[2][1], seg[2][5],
                              seg[3][1], seg[3][5], seg[4][1], seg[4][5], seg[5][1], seg[5][5]};
         3'd2: word = {26'd0, seg[0][6], seg[1][6], seg[2][6], seg[3][6], seg[4][6], seg[5][6]};
         3'd3: word = {20'd0, seg[0][2], seg[0][4], seg[1][2], seg[1][4], seg[2][2], seg[2][4],
                              seg[3][2], seg[3][4], seg[4][2], seg[4][4], seg[5][2], seg[5][4]};
         3'd4: word = {26'd0, seg[0][3], seg[1][3], seg[2][3], seg[3][3], seg[4][3], seg[5][3]};
         default: word = 32'd0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/seg7_hex_writer_if.sv
// -----------------------------------------------------------------------------
// seg7_hex_writer_if
// Request side (start/value/busy/done) and shared data-bus side
// (bus_req/bus_gnt/write_enable/cs_7seg/address/data_write) of the writer.
//   master - the hex writer itself
//   slave  - the environment: requester, arbiter and 7-segment driver
// -----------------------------------------------------------------------------
interface seg7_hex_writer_if;
   logic        start;
   logic [23:0] value;
   logic        busy;
   logic        done;
   logic        bus_req;
   logic        bus_gnt;
   logic        write_enable;
   logic        cs_7seg;
   logic [31:0] address;
   logic [31:0] data_write;

   modport master (
      input  start, value, bus_gnt,
      output busy, done, bus_req, write_enable, cs_7seg, address, data_write
   );

   modport slave (
      output start, value, bus_gnt,
      input  busy, done, bus_req, write_enable, cs_7seg, address, data_write
   );
endinterface

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to 7-segment decoder.
//   digit_i [3:0] - hex digit
//   seg_o   [6:0] - lit pattern, 1 = lit, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_TABLE[digit_i];

endmodule

// File: rtl/seg7_hex_writer.sv
// -----------------------------------------------------------------------------
// seg7_hex_writer
// Takes a six-digit hex value on start, decodes it to segment patterns and
// writes the five segment-plane words to the 7-segment driver over the shared
// bus, holding the bus through a request/grant handshake.
//   clk     - clock
//   reset_n - synchronous, active-low reset
//   bus     - seg7_hex_writer_if.master (request side + bus side)
// Parameters:
//   BASE_ADDR     - address of plane 0; planes at BASE_ADDR..BASE_ADDR+4
//   BLANK_LEADING - 1: blank digits above the most significant non-zero one
// -----------------------------------------------------------------------------
module seg7_hex_writer
   import seg7_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'd3,
   parameter bit          BLANK_LEADING = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   seg7_hex_writer_if.master bus
);

   localparam logic [2:0] LAST_PLANE = 3'(NUM_PLANES - 1);

   state_t      state_q, state_d;
   logic [2:0]  index_q, index_d;
   logic [23:0] work_q, work_d;
   logic [23:0] pend_val_q, pend_val_d;
   logic        pend_q, pend_d;

   seg_vec_t                raw_seg_s;
   seg_vec_t                seg_s;
   logic [NUM_DIGITS-1:0]   shown_s;
   logic                    wr_s;

   // Per-digit decode of the working register, with optional leading blanking.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_to_seg7 u_dec (
         .digit_i (work_q[4*g +: 4]),
         .seg_o   (raw_seg_s[g])
      );
      // A digit stays visible if it or any digit above it is non-zero.
      if (g == 0) begin : g_lsd
         assign shown_s[g] = 1'b1;
      end else begin : g_upper
         assign shown_s[g] = |work_q[23:4*g];
      end
      assign seg_s[g] = (BLANK_LEADING && !shown_s[g]) ? 7'd0 : raw_seg_s[g];
   end

   // State, plane index, working value and pending-start registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         index_q    <= 3'd0;
         work_q     <= 24'd0;
         pend_val_q <= 24'd0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         work_q     <= work_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
      end
   end

   // Next-state logic: sequencing, plane advance and start capture.
   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      work_d     = work_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;

      // A start during an active sequence is parked; the newest one wins.
      if (bus.start && ((state_q == REQ) || (state_q == WRITE))) begin
         pend_val_d = bus.value;
         pend_d     = 1'b1;
      end else begin
         pend_d     = pend_q;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               work_d  = bus.value;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (bus.bus_gnt) begin
               state_d = WRITE;
               index_d = 3'd0;
            end else begin
               state_d = REQ;
            end
         end
         WRITE: begin
            // Without grant the index holds so the same plane is retried.
            if (bus.bus_gnt) begin
               if (index_q == LAST_PLANE) begin
                  state_d = DONE;
                  index_d = 3'd0;
               end else begin
                  index_d = index_q + 3'd1;
               end
            end else begin
               index_d = index_q;
            end
         end
         DONE: begin
            // A start arriving in this very cycle is newer than any parked one.
            if (bus.start) begin
               work_d  = bus.value;
               pend_d  = 1'b0;
               state_d = REQ;
            end else if (pend_q) begin
               work_d  = pend_val_q;
               pend_d  = 1'b0;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            index_d = 3'd0;
         end
      endcase
   end

   // Status and bus outputs, decoded from state, plane index and grant.
   always_comb begin
      wr_s             = (state_q == WRITE) && bus.bus_gnt;
      bus.busy         = (state_q != IDLE);
      bus.done         = (state_q == DONE);
      bus.bus_req      = (state_q == REQ) || (state_q == WRITE);
      bus.write_enable = wr_s;
      bus.cs_7seg      = wr_s;
      if (wr_s) begin
         bus.address    = BASE_ADDR + {29'd0, index_q};
         bus.data_write = pack_plane(index_q, seg_s);
      end else begin
         bus.address    = 32'd0;
         bus.data_write = 32'd0;
      end
   end

endmodule

// File: tb/tb_seg7_hex_writer.sv
module tb_seg7_hex_writer;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seg7_hex_writer_if bus_a();
   seg7_hex_writer_if bus_b();

   // The blanking instance runs in lockstep on the same inputs.
   assign bus_b.start   = bus_a.start;
   assign bus_b.value   = bus_a.value;
   assign bus_b.bus_gnt = bus_a.bus_gnt;

   seg7_hex_writer #(.BASE_ADDR(32'd3), .BLANK_LEADING(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_a));
   seg7_hex_writer #(.BASE_ADDR(32'd3), .BLANK_LEADING(1'b1)) dut_blank (
      .clk(clk), .reset_n(reset_n), .bus(bus_b));

   int n_checks = 0;
   int n_fail   = 0;

   int HEX [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

   // Reference plane word straight from the segment/bit placement rules.
   function automatic int model_plane(int value, bit blank, int p);
      int w, s;
      w = 0;
      for (int d = 0; d < 6; d++) begin
         s = HEX[(value >> (4*d)) & 15];
         if (blank && d != 0 && (value >> (4*d)) == 0) s = 0;
         case (p)
            0: w |= ((s >> 0) & 1) << (5 - d);
            1: w |= (((s >> 1) & 1) << (11 - 2*d)) | (((s >> 5) & 1) << (10 - 2*d));
            2: w |= ((s >> 6) & 1) << (5 - d);
            3: w |= (((s >> 2) & 1) << (11 - 2*d)) | (((s >> 4) & 1) << (10 - 2*d));
            default: w |= ((s >> 3) & 1) << (5 - d);
         endcase
      end
      return w;
   endfunction

   task automatic chk1(string name, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(string tag, bit b, bit e_busy, bit e_done, bit e_req,
                             bit e_we, logic [31:0] e_addr, logic [31:0] e_data);
      logic o_busy, o_done, o_req, o_we, o_cs;
      logic [31:0] o_addr, o_data;
      if (b) begin
         o_busy = bus_b.busy; o_done = bus_b.done; o_req = bus_b.bus_req;
         o_we = bus_b.write_enable; o_cs = bus_b.cs_7seg;
         o_addr = bus_b.address; o_data = bus_b.data_write;
      end else begin
         o_busy = bus_a.busy; o_done = bus_a.done; o_req = bus_a.bus_req;
         o_we = bus_a.write_enable; o_cs = bus_a.cs_7seg;
         o_addr = bus_a.address; o_data = bus_a.data_write;
      end
      chk1({tag, " busy"}, o_busy, e_busy);
      chk1({tag, " done"}, o_done, e_done);
      chk1({tag, " bus_req"}, o_req, e_req);
      chk1({tag, " write_enable"}, o_we, e_we);
      chk1({tag, " cs_7seg"}, o_cs, e_we);
      chk32({tag, " address"}, o_addr, e_addr);
      chk32({tag, " data_write"}, o_data, e_data);
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [23:0]      value;
      bit               blank;
      logic [0:4][31:0] plane;
   } vec_t;

   vec_t vecs [6];

   // Full sequence with grant held: REQ cycle 1, writes 2..6, done 7, idle 8.
   task automatic run_vector(int k);
      string t;
      bus_a.value = vecs[k].value; bus_a.start = 1'b1; bus_a.bus_gnt = 1'b1;
      smp();
      check_outs($sformatf("vec%0d c0", k), vecs[k].blank, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      adv();
      bus_a.start = 1'b0;
      smp();
      check_outs($sformatf("vec%0d c1", k), vecs[k].blank, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      adv();
      for (int i = 0; i < 5; i++) begin
         t = $sformatf("vec%0d c%0d", k, i + 2);
         smp();
         check_outs(t, vecs[k].blank, 1'b1, 1'b0, 1'b1, 1'b1, 32'(3 + i), vecs[k].plane[i]);
         adv();
      end
      smp();
      check_outs($sformatf("vec%0d c7", k), vecs[k].blank, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      adv();
      smp();
      check_outs($sformatf("vec%0d c8", k), vecs[k].blank, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      adv();
   endtask

   // Up to three starts at given cycles; expects sequences for e0 then e1.
   task automatic run_scen(string tag, int c0, logic [23:0] v0, int c1, logic [23:0] v1,
                           int c2, logic [23:0] v2, logic [23:0] e0, logic [23:0] e1);
      int exp_addr[$];
      int exp_data[$];
      int n_done, n_wr;
      n_done = 0; n_wr = 0;
      for (int p = 0; p < 5; p++) begin exp_addr.push_back(3 + p); exp_data.push_back(model_plane(int'(e0), 1'b0, p)); end
      for (int p = 0; p < 5; p++) begin exp_addr.push_back(3 + p); exp_data.push_back(model_plane(int'(e1), 1'b0, p)); end
      bus_a.bus_gnt = 1'b1;
      for (int c = 0; c < 22; c++) begin
         bus_a.start = 1'b0;
         if (c == c0) begin bus_a.start = 1'b1; bus_a.value = v0; end
         if (c == c1) begin bus_a.start = 1'b1; bus_a.value = v1; end
         if (c == c2) begin bus_a.start = 1'b1; bus_a.value = v2; end
         smp();
         if (bus_a.done === 1'b1) n_done++;
         if (bus_a.write_enable === 1'b1) begin
            n_wr++;
            if (exp_addr.size() == 0) begin
               chk32({tag, " extra write addr"}, bus_a.address, 32'd0);
            end else begin
               chk32({tag, " addr"}, bus_a.address, 32'(exp_addr.pop_front()));
               chk32({tag, " data"}, bus_a.data_write, 32'(exp_data.pop_front()));
            end
         end
         adv();
      end
      bus_a.start = 1'b0;
      chk32({tag, " done pulses"}, 32'(n_done), 32'd2);
      chk32({tag, " writes"}, 32'(n_wr), 32'd10);
      smp();
      chk1({tag, " idle at end"}, bus_a.busy, 1'b0);
      adv();
   endtask

   // Cycle-level reference state for the random run.
   bit m_busy, m_done, m_started, m_haspend;
   int m_cur, m_pend, m_wr;

   initial begin
      bit st, gnt, e_req, e_we;
      int val;

      vecs[0] = '{24'h012345, 1'b0, {32'h2D, 32'h7AB, 32'h3C, 32'hA9B, 32'h2D}};
      vecs[1] = '{24'h888888, 1'b0, {32'h3F, 32'hFFF, 32'h3F, 32'hFFF, 32'h3F}};
      vecs[2] = '{24'h000000, 1'b0, {32'h3F, 32'hFFF, 32'h00, 32'hFFF, 32'h3F}};
      vecs[3] = '{24'h000000, 1'b1, {32'h20, 32'hC00, 32'h00, 32'hC00, 32'h20}};
      vecs[4] = '{24'h888888, 1'b1, {32'h3F, 32'hFFF, 32'h3F, 32'hFFF, 32'h3F}};
      vecs[5] = '{24'h00A000, 1'b1, {32'h3C, 32'hFF0, 32'h04, 32'hFF0, 32'h38}};

      reset_n = 1'b0; bus_a.start = 1'b0; bus_a.value = 24'd0; bus_a.bus_gnt = 1'b1;
      adv(); adv();
      smp();
      check_outs("reset a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_outs("reset b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      adv();
      reset_n = 1'b1;

      for (int k = 0; k < 6; k++) run_vector(k);

      // Grant withdrawn for three cycles after the second write.
      bus_a.value = 24'h012345; bus_a.start = 1'b1; bus_a.bus_gnt = 1'b1;
      adv();
      bus_a.start = 1'b0;
      adv();
      smp(); chk32("gdrop w0 addr", bus_a.address, 32'd3); adv();
      smp(); chk32("gdrop w1 addr", bus_a.address, 32'd4); adv();
      bus_a.bus_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         check_outs($sformatf("gdrop hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
         adv();
      end
      bus_a.bus_gnt = 1'b1;
      smp(); check_outs("gdrop resume", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 32'h3C); adv();
      smp(); chk32("gdrop w3 addr", bus_a.address, 32'd6); adv();
      smp(); check_outs("gdrop w4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd7, 32'h2D); adv();
      smp(); chk1("gdrop done", bus_a.done, 1'b1); adv();

      run_scen("pend", 0, 24'h111111, 3, 24'h222222, 5, 24'h333333, 24'h111111, 24'h333333);
      run_scen("donestart", 0, 24'h0000F1, 7, 24'hABCDEF, -1, 24'h0, 24'h0000F1, 24'hABCDEF);

      // Reset during the third write, with a start already parked.
      bus_a.value = 24'h012345; bus_a.start = 1'b1; bus_a.bus_gnt = 1'b1;
      adv();
      bus_a.start = 1'b0;
      adv(); adv();
      bus_a.start = 1'b1; bus_a.value = 24'h888888;
      adv();
      bus_a.start = 1'b0; reset_n = 1'b0;
      smp(); chk32("rst w2 addr", bus_a.address, 32'd5);
      adv();
      reset_n = 1'b1;
      smp();
      check_outs("midrst a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check_outs("midrst b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      adv();
      run_vector(0);

      // Random starts, values and grant against the reference state.
      m_busy = 0; m_done = 0; m_started = 0; m_haspend = 0; m_cur = 0; m_pend = 0; m_wr = 0;
      for (int c = 0; c < 400; c++) begin
         st  = ($urandom_range(0, 7) == 0);
         gnt = ($urandom_range(0, 3) != 0);
         val = int'($urandom_range(0, 24'hFFFFFF) >> (4 * $urandom_range(0, 6)));
         bus_a.start = st; bus_a.value = val[23:0]; bus_a.bus_gnt = gnt;
         e_req = m_busy && !m_done;
         e_we  = e_req && gnt && m_started;
         smp();
         check_outs("rnd", 1'b0, m_busy, m_done, e_req, e_we,
                    e_we ? 32'(3 + m_wr) : 32'd0,
                    e_we ? 32'(model_plane(m_cur, 1'b0, m_wr)) : 32'd0);
         chk32("rnd blank data", bus_b.data_write,
               e_we ? 32'(model_plane(m_cur, 1'b1, m_wr)) : 32'd0);
         if (!m_busy) begin
            if (st) begin m_busy = 1; m_cur = val; m_wr = 0; m_started = 0; end
         end else if (m_done) begin
            m_done = 0; m_started = 0; m_wr = 0;
            if (st) m_cur = val;
            else if (m_haspend) m_cur = m_pend;
            else m_busy = 0;
            m_haspend = 0;
         end else begin
            if (st) begin m_pend = val; m_haspend = 1; end
            if (gnt) begin
               if (!m_started) m_started = 1;
               else begin
                  m_wr++;
                  if (m_wr == 5) m_done = 1;
               end
            end
         end
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
